// File: rtl/board_write_arbiter.sv
// Round-robin arbiter sharing the board-RAM write port among NUM_REQ burst requesters.
// Bursts are atomic; a requester that stalls mid-burst for STALL_LIMIT cycles is aborted.
module board_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 4,
    parameter int STALL_LIMIT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          last,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        writeEn,
    output logic [ADDR_W-1:0]           writeAddr,
    output logic [DATA_W-1:0]           data2Write,
    output logic                        busy,
    output logic                        abort
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        ARB,
        GRANT
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                we_q, we_d;
    logic                abort_q, abort_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [IDX_W-1:0]    sel;
    logic                sel_valid;
    logic [IDX_W:0]      cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Scan upward from the requester after the last one served, wrapping once.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!sel_valid && req[cand[IDX_W-1:0]]) begin
                sel       = cand[IDX_W-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        we_d    = 1'b0;
        abort_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ARB: begin
                gnt_d = '0;
                if (!hold && sel_valid) begin
                    gnt_d[sel] = 1'b1;
                    idx_d      = sel;
                    stall_d    = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (req[idx_q]) begin
                    we_d    = 1'b1;
                    addr_d  = addr_arr[idx_q];
                    data_d  = data_arr[idx_q];
                    stall_d = '0;
                    if (last[idx_q]) begin
                        gnt_d   = '0;
                        ptr_d   = idx_q;
                        state_d = ARB;
                    end
                end else if (stall_q == STALL_W'(STALL_LIMIT - 1)) begin
                    // This idle cycle is the STALL_LIMIT-th in a row: give the port up.
                    gnt_d   = '0;
                    abort_d = 1'b1;
                    ptr_d   = idx_q;
                    stall_d = '0;
                    state_d = ARB;
                end else if (stall_q != STALL_W'(STALL_LIMIT)) begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            stall_q <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign gnt        = gnt_q;
    assign writeEn    = we_q;
    assign writeAddr  = addr_q;
    assign data2Write = data_q;
    assign busy       = (state_q == GRANT);
    assign abort      = abort_q;

endmodule

// File: tb/tb_board_write_arbiter.sv
// Bench for board_write_arbiter: directed scenarios with literal expectations, then
// randomized burst traffic compared every cycle against a transaction-level model.
module tb_board_write_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 4;
    localparam int STALL_LIMIT = 15;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      hold;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      writeEn;
    logic [ADDR_W-1:0]         writeAddr;
    logic [DATA_W-1:0]         data2Write;
    logic                      busy;
    logic                      abort;

    int tests = 0;
    int fails = 0;

    board_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .req(req), .last(last),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .writeEn(writeEn),
        .writeAddr(writeAddr), .data2Write(data2Write), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, who was served last, how long the owner has idled.
    int                 m_owner = -1;
    int                 m_ptr   = NUM_REQ - 1;
    int                 m_idle  = 0;
    int                 m_acc   = -1;
    int                 m_abort_idx = -1;
    int                 m_c;
    logic [NUM_REQ-1:0] e_gnt   = '0;
    logic               e_we    = 1'b0;
    logic               e_abort = 1'b0;
    logic [ADDR_W-1:0]  e_addr  = '0;
    logic [DATA_W-1:0]  e_data  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1; m_ptr = NUM_REQ - 1; m_idle = 0; m_acc = -1; m_abort_idx = -1;
            e_gnt = '0; e_we = 1'b0; e_abort = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            m_acc = -1; m_abort_idx = -1; e_we = 1'b0; e_abort = 1'b0;
            if (m_owner < 0) begin
                if (!hold && req != '0) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        m_c = (m_ptr + k) % NUM_REQ;
                        if (m_owner < 0 && req[m_c]) m_owner = m_c;
                    end
                    m_idle = 0;
                end
            end else if (req[m_owner]) begin
                m_acc  = m_owner;
                e_we   = 1'b1;
                e_addr = req_addr[m_owner*ADDR_W +: ADDR_W];
                e_data = req_data[m_owner*DATA_W +: DATA_W];
                m_idle = 0;
                if (last[m_owner]) begin
                    m_ptr = m_owner; m_owner = -1;
                end
            end else begin
                m_idle++;
                if (m_idle == STALL_LIMIT) begin
                    e_abort = 1'b1; m_abort_idx = m_owner;
                    m_ptr = m_owner; m_owner = -1; m_idle = 0;
                end
            end
            e_gnt = '0;
            if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        end
    end

    // Every cycle out of reset, all outputs must match the model.
    always @(negedge clk) begin
        if (reset) begin
            tests++;
            if (gnt !== e_gnt || writeEn !== e_we || writeAddr !== e_addr ||
                data2Write !== e_data || busy !== (m_owner >= 0) || abort !== e_abort) begin
                fails++;
                $display("[TB] FAIL cycle_compare t=%0t gnt=%b/%b we=%b/%b addr=%0d/%0d data=%0d/%0d busy=%b/%b abort=%b/%b (actual/required)",
                         $time, gnt, e_gnt, writeEn, e_we, writeAddr, e_addr, data2Write, e_data,
                         busy, (m_owner >= 0), abort, e_abort);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    task automatic set_beat(input int i, input int a, input int d);
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Random requester agents: pending bursts hold their first beat stable until served.
    int                rem [NUM_REQ];
    int                gap [NUM_REQ];
    logic [ADDR_W-1:0] cur_a [NUM_REQ];
    logic [DATA_W-1:0] cur_d [NUM_REQ];

    task automatic apply_stimulus();
        int r;
        logic rb;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_acc == i) begin
                rem[i]--;
                cur_a[i] = ADDR_W'($urandom);
                cur_d[i] = DATA_W'($urandom);
                if (rem[i] > 0) begin
                    r = int'($urandom % 100);
                    if (r < 8) gap[i] = 1 + int'($urandom % 3);
                    else if (r < 11) gap[i] = STALL_LIMIT + 3;
                end
            end
            if (m_abort_idx == i) begin
                rem[i] = 0; gap[i] = 0;
            end
            if (rem[i] == 0 && ($urandom % 3) == 0) begin
                rem[i]   = 1 + int'($urandom % 4);
                gap[i]   = 0;
                cur_a[i] = ADDR_W'($urandom);
                cur_d[i] = DATA_W'($urandom);
            end
            rb = (rem[i] > 0);
            if (m_owner == i && gap[i] > 0) begin
                rb = 1'b0;
                gap[i]--;
            end
            req[i]  = rb;
            last[i] = rb ? (rem[i] == 1) : 1'($urandom);
            if (rem[i] > 0) set_beat(i, int'(cur_a[i]), int'(cur_d[i]));
            else set_beat(i, int'($urandom % 1024), int'($urandom % 16));
        end
        hold = (($urandom % 10) == 0);
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; req = '0; last = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = 0; gap[i] = 0; cur_a[i] = '0; cur_d[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_output("reset_gnt", gnt, 0);
        check_output("reset_we", writeEn, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_abort", abort, 0);
        check_output("reset_addr", writeAddr, 0);

        // Single-beat burst straight out of reset.
        set_beat(0, 37, 3); req = 4'b0001; last = 4'b0001; reset = 1'b1;
        @(negedge clk);
        check_output("t1_gnt", gnt, 4'b0001);
        check_output("t1_busy", busy, 1);
        @(negedge clk);
        check_output("t1_we", writeEn, 1);
        check_output("t1_addr", writeAddr, 37);
        check_output("t1_data", data2Write, 3);
        check_output("t1_gnt_off", gnt, 0);
        check_output("t1_busy_off", busy, 0);
        req = '0; last = '0;
        @(negedge clk);
        check_output("t1_we_off", writeEn, 0);

        // Two-beat burst from requester 0 while requester 2 waits.
        do_reset();
        set_beat(0, 37, 0); set_beat(2, 100, 5); req = 4'b0101; last = 4'b0100;
        @(negedge clk);
        check_output("t2_gnt0", gnt, 4'b0001);
        @(negedge clk);
        check_output("t2_addr_b1", writeAddr, 37);
        check_output("t2_data_b1", data2Write, 0);
        check_output("t2_gnt_b1", gnt, 4'b0001);
        set_beat(0, 38, 3); last = 4'b0101;
        @(negedge clk);
        check_output("t2_addr_b2", writeAddr, 38);
        check_output("t2_data_b2", data2Write, 3);
        check_output("t2_gnt_gap", gnt, 0);
        req = 4'b0100;
        @(negedge clk);
        check_output("t2_gnt2", gnt, 4'b0100);
        check_output("t2_we_idle", writeEn, 0);
        @(negedge clk);
        check_output("t2_addr_r2", writeAddr, 100);
        req = '0; last = '0;
        @(negedge clk);

        // All four requesting single beats continuously: strict rotation with gaps.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_beat(i, 200 + i, i);
        req = 4'b1111; last = 4'b1111;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                check_output("t3_gnt", gnt, 32'd1 << (((c - 1) / 2) % 4));
            end else begin
                check_output("t3_gnt_gap", gnt, 0);
                check_output("t3_addr", writeAddr, 200 + ((c - 2) / 2) % 4);
            end
        end
        req = '0; last = '0;
        @(negedge clk);

        // Requester 1 stalls after one beat and is aborted; requester 2 is next.
        do_reset();
        set_beat(1, 300, 7); set_beat(2, 400, 9); req = 4'b0110; last = 4'b0100;
        @(negedge clk);
        check_output("t4_gnt1", gnt, 4'b0010);
        @(negedge clk);
        check_output("t4_addr", writeAddr, 300);
        req = 4'b0100;
        for (int k = 1; k < STALL_LIMIT; k++) begin
            @(negedge clk);
            check_output("t4_stall_gnt", gnt, 4'b0010);
            check_output("t4_stall_abort", abort, 0);
        end
        @(negedge clk);
        check_output("t4_abort", abort, 1);
        check_output("t4_abort_gnt", gnt, 0);
        @(negedge clk);
        check_output("t4_abort_once", abort, 0);
        check_output("t4_gnt2", gnt, 4'b0100);
        @(negedge clk);
        check_output("t4_addr2", writeAddr, 400);
        req = '0; last = '0;
        @(negedge clk);

        // hold blocks new grants but never cuts a burst short.
        hold = 1'b1; req = 4'b0100; last = 4'b0100; set_beat(2, 55, 1);
        repeat (3) begin
            @(negedge clk);
            check_output("t5_hold_gnt", gnt, 0);
        end
        hold = 1'b0;
        @(negedge clk);
        check_output("t5_release_gnt", gnt, 4'b0100);
        @(negedge clk);
        check_output("t5_addr55", writeAddr, 55);
        last = '0; set_beat(2, 60, 2);
        @(negedge clk);
        check_output("t5_gnt_b", gnt, 4'b0100);
        hold = 1'b1;
        @(negedge clk);
        check_output("t5_addr60", writeAddr, 60);
        check_output("t5_gnt_held", gnt, 4'b0100);
        set_beat(2, 61, 3); last = 4'b0100;
        @(negedge clk);
        check_output("t5_addr61", writeAddr, 61);
        check_output("t5_burst_end", gnt, 0);
        set_beat(2, 62, 4);
        repeat (2) begin
            @(negedge clk);
            check_output("t5_hold_again", gnt, 0);
        end
        hold = 1'b0;
        @(negedge clk);
        check_output("t5_regrant", gnt, 4'b0100);
        @(negedge clk);
        check_output("t5_addr62", writeAddr, 62);
        req = '0; last = '0;
        @(negedge clk);

        // Asynchronous reset while a write is on the port.
        req = 4'b0001; last = '0; set_beat(0, 70, 5);
        @(negedge clk);
        check_output("t6_gnt0", gnt, 4'b0001);
        @(negedge clk);
        check_output("t6_we", writeEn, 1);
        #2 reset = 1'b0;
        #1;
        check_output("t6_async_we", writeEn, 0);
        check_output("t6_async_gnt", gnt, 0);
        check_output("t6_async_busy", busy, 0);
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) set_beat(i, 500 + i, i);
        req = 4'b1111; last = 4'b1111; reset = 1'b1;
        @(negedge clk);
        check_output("t6_first_gnt", gnt, 4'b0001);
        @(negedge clk);
        req = '0; last = '0;
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            apply_stimulus();
        end
        @(negedge clk);
        req = '0; last = '0; hold = 1'b0;
        repeat (STALL_LIMIT + 5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
